// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for a 5-stage RISC-V pipeline: per-stage enables and flushes,
// a halt/drain/resume sequence, a memory-wait timeout and saturating performance counters.
module pipeline_stall_ctrl #(
   parameter int TIMEOUT      = 16,
   parameter int DRAIN_CYCLES = 4,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WAIT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [2:0] {RUN, MEM_WAIT, DRAIN, HALTED, ERROR} state_t;

   state_t             state_reg, state_next, eff_state;
   logic               ret_drain_reg, ret_drain_next;
   logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
   logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
   logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;
   logic [CNT_W-1:0]   flush_cnt_reg, flush_cnt_next;
   logic               mem_err_reg, mem_err_next;
   logic               mstall, stall_inc, flush_inc;

   assign mstall = dmem_req & ~dmem_ready;
   // A resolved memory wait behaves as the state it interrupted in that same cycle
   assign eff_state = (state_reg == MEM_WAIT) ? (ret_drain_reg ? DRAIN : RUN) : state_reg;

   always_comb begin
      pc_en          = 1'b1;
      if_id_en       = 1'b1;
      id_ex_en       = 1'b1;
      ex_mem_en      = 1'b1;
      mem_wb_en      = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      mem_wb_flush   = 1'b0;
      halted         = 1'b0;
      state_next     = state_reg;
      ret_drain_next = ret_drain_reg;
      wait_cnt_next  = wait_cnt_reg;
      drain_cnt_next = drain_cnt_reg;
      mem_err_next   = mem_err_reg;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;

      case (state_reg)
         HALTED: begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
            halted = 1'b1;
            if (resume) state_next = RUN;
         end
         ERROR: begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
         end
         default: begin
            if (mstall) begin
               {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
               mem_wb_flush = 1'b1;
               stall_inc    = 1'b1;
               if (state_reg != MEM_WAIT) ret_drain_next = (state_reg == DRAIN);
               if (wait_cnt_reg == WAIT_W'(TIMEOUT - 1)) begin
                  state_next    = ERROR;
                  mem_err_next  = 1'b1;
                  wait_cnt_next = '0;
               end else begin
                  state_next    = MEM_WAIT;
                  wait_cnt_next = wait_cnt_reg + 1'b1;
               end
            end else begin
               wait_cnt_next = '0;
               state_next    = eff_state;
               if (eff_state == RUN) begin
                  if (branch_taken) begin
                     if_id_flush = 1'b1;
                     flush_inc   = 1'b1;
                  end
                  // A taken branch keeps fetching its target; load-use then only bubbles ID/EX
                  if (load_use) begin
                     id_ex_flush = 1'b1;
                     stall_inc   = 1'b1;
                     if (!branch_taken) begin
                        pc_en    = 1'b0;
                        if_id_en = 1'b0;
                     end
                  end
                  if (halt_req) begin
                     state_next     = DRAIN;
                     drain_cnt_next = '0;
                  end
               end else begin
                  pc_en     = 1'b0;
                  stall_inc = 1'b1;
                  if (load_use) begin
                     if_id_en    = 1'b0;
                     id_ex_flush = 1'b1;
                  end else begin
                     if_id_flush = 1'b1;
                     if (drain_cnt_reg == DRAIN_W'(DRAIN_CYCLES - 1)) state_next = HALTED;
                     else drain_cnt_next = drain_cnt_reg + 1'b1;
                  end
               end
            end
         end
      endcase

      stall_cnt_next = (stall_inc && stall_cnt_reg != '1) ? stall_cnt_reg + 1'b1 : stall_cnt_reg;
      flush_cnt_next = (flush_inc && flush_cnt_reg != '1) ? flush_cnt_reg + 1'b1 : flush_cnt_reg;

      if (!rst_n) begin
         {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
         {if_id_flush, id_ex_flush, mem_wb_flush}         = '1;
         halted = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= RUN;
         ret_drain_reg <= 1'b0;
         wait_cnt_reg  <= '0;
         drain_cnt_reg <= '0;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
         mem_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         ret_drain_reg <= ret_drain_next;
         wait_cnt_reg  <= wait_cnt_next;
         drain_cnt_reg <= drain_cnt_next;
         stall_cnt_reg <= stall_cnt_next;
         flush_cnt_reg <= flush_cnt_next;
         mem_err_reg   <= mem_err_next;
      end
   end

   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;
   assign mem_err   = mem_err_reg;

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It consumes the hazard detection unit's load-use indication, the ID-stage branch decision (zero & beq) and the data-memory ready handshake. It drives per-stage register enables and flushes, sequences a halt/drain/resume procedure and detects memory timeouts. It also keeps saturating stall and flush performance counters.

Parameters:
TIMEOUT, 16, consecutive memory-wait cycles (including the first) after which ERROR is entered
DRAIN_CYCLES, 4, bubble cycles injected after a halt request before HALTED
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
load_use  input  1  load-use hazard from hazard detection unit
branch_taken  input  1  ID-stage branch resolved taken (zero & beq)
dmem_req  input  1  MEM stage holds a load or store
dmem_ready  input  1  data memory completes access this cycle
halt_req  input  1  request to drain and halt (level)
resume  input  1  one-cycle pulse, leave HALTED
pc_en  output  1  PC write enable
if_id_en  output  1  IF/ID write enable
id_ex_en  output  1  ID/EX write enable
ex_mem_en  output  1  EX/MEM write enable
mem_wb_en  output  1  MEM/WB write enable
if_id_flush  output  1  IF/ID loads NOP
id_ex_flush  output  1  ID/EX loads bubble (control zeroed)
mem_wb_flush  output  1  MEM/WB loads bubble
halted  output  1  core halted
mem_err  output  1  sticky memory timeout flag
stall_cnt  output  CNT_W  saturating count of stall cycles
flush_cnt  output  CNT_W  saturating count of branch flushes

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED, ERROR. Registers: state, wait_cnt, drain_cnt, stall_cnt, flush_cnt, mem_err.
- Reset: clk edge with rst_n=0 sets state=RUN, all counters 0, mem_err=0. While rst_n=0, outputs are forced: all *_en=0, all *_flush=1, halted=0.
- Control outputs are combinational from state plus inputs, so they act in the same cycle. Default: all *_en=1, all *_flush=0.
- mstall = dmem_req & ~dmem_ready.
- Priority in RUN/MEM_WAIT/DRAIN, highest first:
  1. mstall: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_flush=1. Enter or stay in MEM_WAIT; wait_cnt++. If wait_cnt==TIMEOUT-1 while still mstall, go to ERROR and set mem_err=1.
  2. branch_taken, RUN only: if_id_flush=1; pc_en=1; flush_cnt++.
  3. load_use: pc_en=0, if_id_en=0, id_ex_flush=1.
- Resolving a stall: when mstall drops in MEM_WAIT, wait_cnt=0 and state returns to the state held before the wait (RUN or DRAIN; store a return bit). The remaining priorities are evaluated in that same cycle.
- Halt request: halt_req sampled in RUN with no mstall moves to DRAIN with drain_cnt=0; the branch/load-use in that cycle are still honoured.
- DRAIN: pc_en=0, if_id_flush=1, branch_taken ignored. load_use overrides to if_id_en=0, if_id_flush=0, id_ex_flush=1. drain_cnt advances only in cycles with no mstall and no load_use. At drain_cnt==DRAIN_CYCLES-1 the next state is HALTED.
- HALTED: all *_en=0, halted=1, inputs other than resume ignored. resume=1 moves to RUN next cycle; halt_req still high then re-enters DRAIN.
- ERROR: all *_en=0, flushes 0, mem_err=1. Only reset exits.
- stall_cnt: +1 each cycle with mstall, load_use-stall or DRAIN bubble. Saturates at all ones; no wrap.
- flush_cnt: +1 per cycle with branch flush applied. Saturates at all ones.
- Simultaneous mstall, branch_taken and load_use: only the mstall action applies. The branch is not counted; it is re-seen because IF/ID is frozen.

Test Plan:
- Reset with all inputs 0, then release → pc_en and all *_en=1, flushes=0, counters=0, halted=0.
- load_use=1 for 1 cycle in RUN → pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cnt=1.
- branch_taken=1 together with load_use=1 → if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt=1.
- dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1 → 3 frozen cycles with mem_wb_flush=1, then RUN; stall_cnt=3, mem_err=0. Repeat with 16 not-ready cycles → ERROR, mem_err=1 held until reset.
- halt_req=1 in RUN with one load_use mid-drain → 5 drain-phase cycles with pc_en=0, then halted=1. A resume pulse returns to RUN with pc_en=1.
- Force 65535 load-use cycles, then 2 more → stall_cnt stays 16'hFFFF; rst_n=0 mid-MEM_WAIT → state RUN, wait_cnt=0 after the edge.
